// File: rtl/i3c_ccc_pkg.sv
// rtl/i3c_ccc_pkg.sv - shared mode codes, state encoding and defaults for the broadcast-CCC sequencer
package i3c_ccc_pkg;

    localparam logic [2:0] TX_SERIAL = 3'b001;
    localparam logic [2:0] TX_TBIT   = 3'b011;
    localparam logic [2:0] TX_RSTART = 3'b100;
    localparam logic [2:0] RX_ARB    = 3'b010;
    localparam logic [2:0] RX_ACK    = 3'b000;

    localparam int DEF_BCAST_ADDR = 46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCAST,
        ST_ACK,
        ST_RSTART,
        ST_CCC,
        ST_CCC_T,
        ST_DATA,
        ST_DATA_T
    } state_t;

endpackage

// File: rtl/ccc_byte_ctr.sv
// rtl/ccc_byte_ctr.sv - CCC data byte index, length clamp, last-byte compare and regf address adder
module ccc_byte_ctr #(
    parameter int ADDR_W    = 12,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_len_zero,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_addr_cur,
    output logic [ADDR_W-1:0] o_addr_nxt
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else if (i_load) begin
            base_q <= i_base_addr;
            len_q  <= (i_len > MAX_LEN) ? MAX_LEN : i_len;
            idx_q  <= '0;
        end else if (i_inc) begin
            idx_q  <= idx_q + LEN_W'(1);
        end
    end

    assign o_len_zero = (len_q == '0);
    assign o_last     = (idx_q == len_q - LEN_W'(1));
    // Address wraps modulo 2^ADDR_W by construction of the adder width.
    assign o_addr_cur = base_q + ADDR_W'(idx_q);
    assign o_addr_nxt = o_addr_cur + ADDR_W'(1);

endmodule

// File: rtl/bcast_ccc_seq.sv
// rtl/bcast_ccc_seq.sv - broadcast 7E+W / CCC / data sequencer; NACK retry path under BCAST_CCC_RETRY_EN
module bcast_ccc_seq
    import i3c_ccc_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int BCAST_ADDR = DEF_BCAST_ADDR,
    parameter int MAX_BYTES  = 4,
    parameter int RETRY_MAX  = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_i3cengine_en,
    input  logic [ADDR_W-1:0]                i_ccc_regf_addr,
    input  logic [ADDR_W-1:0]                i_data_regf_addr,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   i_data_len,
    input  logic                             i_tx_mode_done,
    input  logic                             i_rx_mode_done,
    input  logic                             i_rx_ack_nack,
    input  logic                             i_scl_neg_edge,
    output logic                             o_pp_od,
    output logic                             o_bit_cnt_en,
    output logic                             o_regf_rd_en,
    output logic                             o_tx_en,
    output logic                             o_rx_en,
    output logic [ADDR_W-1:0]                o_regf_addr,
    output logic [2:0]                       o_tx_mode,
    output logic [2:0]                       o_rx_mode,
    output logic                             o_i3cengine_done,
    output logic                             o_ccc_nack
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ccc_addr_q;
    logic              load, inc;
    logic              len_zero, last_byte;
    logic [ADDR_W-1:0] data_addr_cur, data_addr_nxt;
    logic              tx_step, rx_step;

    logic              pp_od_d, bit_cnt_en_d, regf_rd_en_d, tx_en_d, rx_en_d;
    logic [ADDR_W-1:0] regf_addr_d;
    logic [2:0]        tx_mode_d, rx_mode_d;
    logic              done_d, nack_d;

    assign tx_step = i_tx_mode_done && i_scl_neg_edge;
    assign rx_step = i_rx_mode_done && i_scl_neg_edge;

`ifdef BCAST_CCC_RETRY_EN
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);
    logic [RETRY_W-1:0] retry_cnt_q;
    logic               retry_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            retry_cnt_q <= '0;
        else if (load)
            retry_cnt_q <= '0;
        else if (retry_inc)
            retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
    end
`endif

    ccc_byte_ctr #(
        .ADDR_W    (ADDR_W),
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) u_byte_ctr (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (load),
        .i_inc       (inc),
        .i_base_addr (i_data_regf_addr),
        .i_len       (i_data_len),
        .o_len_zero  (len_zero),
        .o_last      (last_byte),
        .o_addr_cur  (data_addr_cur),
        .o_addr_nxt  (data_addr_nxt)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        inc     = 1'b0;
        done_d  = 1'b0;
        nack_d  = 1'b0;
`ifdef BCAST_CCC_RETRY_EN
        retry_inc = 1'b0;
`endif
        if (state_q != ST_IDLE && !i_i3cengine_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_i3cengine_en) begin
                        load    = 1'b1;
                        state_d = ST_BCAST;
                    end
                end
                ST_BCAST:  if (tx_step) state_d = ST_ACK;
                ST_ACK: begin
                    if (rx_step) begin
                        if (!i_rx_ack_nack) begin
                            state_d = ST_CCC;
`ifdef BCAST_CCC_RETRY_EN
                        end else if (retry_cnt_q < RETRY_W'(RETRY_MAX)) begin
                            retry_inc = 1'b1;
                            state_d   = ST_RSTART;
`endif
                        end else begin
                            done_d  = 1'b1;
                            nack_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
`ifdef BCAST_CCC_RETRY_EN
                ST_RSTART: if (tx_step) state_d = ST_BCAST;
`endif
                ST_CCC:    if (tx_step) state_d = ST_CCC_T;
                ST_CCC_T: begin
                    if (tx_step) begin
                        if (len_zero) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA:   if (tx_step) state_d = ST_DATA_T;
                ST_DATA_T: begin
                    if (tx_step) begin
                        if (last_byte) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            inc     = 1'b1;
                            state_d = ST_DATA;
                        end
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decode from the next state so they land together with the state register.
    always_comb begin
        pp_od_d      = 1'b0;
        bit_cnt_en_d = 1'b0;
        regf_rd_en_d = 1'b0;
        tx_en_d      = 1'b0;
        rx_en_d      = 1'b0;
        regf_addr_d  = '0;
        tx_mode_d    = 3'b000;
        rx_mode_d    = 3'b000;
        case (state_d)
            ST_BCAST: begin
                tx_en_d      = 1'b1;
                tx_mode_d    = TX_SERIAL;
                rx_en_d      = 1'b1;
                rx_mode_d    = RX_ARB;
                regf_rd_en_d = 1'b1;
                regf_addr_d  = ADDR_W'(BCAST_ADDR);
                bit_cnt_en_d = 1'b1;
            end
            ST_ACK: begin
                rx_en_d   = 1'b1;
                rx_mode_d = RX_ACK;
            end
            ST_RSTART: begin
                tx_en_d   = 1'b1;
                tx_mode_d = TX_RSTART;
            end
            ST_CCC: begin
                tx_en_d      = 1'b1;
                tx_mode_d    = TX_SERIAL;
                regf_rd_en_d = 1'b1;
                regf_addr_d  = ccc_addr_q;
                bit_cnt_en_d = 1'b1;
                pp_od_d      = 1'b1;
            end
            ST_CCC_T, ST_DATA_T: begin
                tx_en_d   = 1'b1;
                tx_mode_d = TX_TBIT;
                pp_od_d   = 1'b1;
            end
            ST_DATA: begin
                tx_en_d      = 1'b1;
                tx_mode_d    = TX_SERIAL;
                regf_rd_en_d = 1'b1;
                regf_addr_d  = (state_q == ST_DATA_T) ? data_addr_nxt : data_addr_cur;
                bit_cnt_en_d = 1'b1;
                pp_od_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= ST_IDLE;
            ccc_addr_q       <= '0;
            o_pp_od          <= 1'b0;
            o_bit_cnt_en     <= 1'b0;
            o_regf_rd_en     <= 1'b0;
            o_tx_en          <= 1'b0;
            o_rx_en          <= 1'b0;
            o_regf_addr      <= '0;
            o_tx_mode        <= 3'b000;
            o_rx_mode        <= 3'b000;
            o_i3cengine_done <= 1'b0;
            o_ccc_nack       <= 1'b0;
        end else begin
            state_q          <= state_d;
            if (load)
                ccc_addr_q   <= i_ccc_regf_addr;
            o_pp_od          <= pp_od_d;
            o_bit_cnt_en     <= bit_cnt_en_d;
            o_regf_rd_en     <= regf_rd_en_d;
            o_tx_en          <= tx_en_d;
            o_rx_en          <= rx_en_d;
            o_regf_addr      <= regf_addr_d;
            o_tx_mode        <= tx_mode_d;
            o_rx_mode        <= rx_mode_d;
            o_i3cengine_done <= done_d;
            o_ccc_nack       <= nack_d;
        end
    end

endmodule

// File: tb/tb_bcast_ccc_seq.sv
// tb/tb_bcast_ccc_seq.sv - scoreboard bench for bcast_ccc_seq; expectations follow BCAST_CCC_RETRY_EN
module tb_bcast_ccc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [11:0] ccc_addr;
    logic [11:0] data_addr;
    logic [2:0]  data_len;
    logic        tx_done, rx_done, ack_nack, neg;

    logic        o_pp_od, o_bit_cnt_en, o_regf_rd_en, o_tx_en, o_rx_en;
    logic [11:0] o_regf_addr;
    logic [2:0]  o_tx_mode, o_rx_mode;
    logic        o_done, o_nack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] exp_q[$];
    logic [22:0] prev_sig;

    always #5 clk = ~clk;

    bcast_ccc_seq dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_i3cengine_en   (en),
        .i_ccc_regf_addr  (ccc_addr),
        .i_data_regf_addr (data_addr),
        .i_data_len       (data_len),
        .i_tx_mode_done   (tx_done),
        .i_rx_mode_done   (rx_done),
        .i_rx_ack_nack    (ack_nack),
        .i_scl_neg_edge   (neg),
        .o_pp_od          (o_pp_od),
        .o_bit_cnt_en     (o_bit_cnt_en),
        .o_regf_rd_en     (o_regf_rd_en),
        .o_tx_en          (o_tx_en),
        .o_rx_en          (o_rx_en),
        .o_regf_addr      (o_regf_addr),
        .o_tx_mode        (o_tx_mode),
        .o_rx_mode        (o_rx_mode),
        .o_i3cengine_done (o_done),
        .o_ccc_nack       (o_nack)
    );

    wire [24:0] obs = {o_tx_en, o_tx_mode, o_rx_en, o_rx_mode, o_regf_rd_en,
                       o_regf_addr, o_bit_cnt_en, o_pp_od, o_done, o_nack};

    function automatic logic [24:0] ph(input logic te, input logic [2:0] tm, input logic re,
                                       input logic [2:0] rm, input logic rd, input logic [11:0] a,
                                       input logic bc, input logic pp, input logic dn, input logic nk);
        return {te, tm, re, rm, rd, a, bc, pp, dn, nk};
    endfunction

    function automatic logic [24:0] e_bcast();  return ph(1, 3'b001, 1, 3'b010, 1, 12'd46, 1, 0, 0, 0); endfunction
    function automatic logic [24:0] e_ack();    return ph(0, 3'b000, 1, 3'b000, 0, 12'd0, 0, 0, 0, 0); endfunction
    function automatic logic [24:0] e_rstart(); return ph(1, 3'b100, 0, 3'b000, 0, 12'd0, 0, 0, 0, 0); endfunction
    function automatic logic [24:0] e_tbit();   return ph(1, 3'b011, 0, 3'b000, 0, 12'd0, 0, 1, 0, 0); endfunction
    function automatic logic [24:0] e_ser(input logic [11:0] a); return ph(1, 3'b001, 0, 3'b000, 1, a, 1, 1, 0, 0); endfunction
    function automatic logic [24:0] e_done(input logic nk); return ph(0, 3'b000, 0, 3'b000, 0, 12'd0, 0, 0, 1, nk); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: every new non-idle output pattern, and every done/nack, is one scoreboard entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sig = '0;
        end else begin
            if (obs[1] || obs[0] || (obs[24:2] != prev_sig && obs[24:2] != '0)) begin
                if (exp_q.size() == 0)
                    chk("phase_unexpected", {7'd0, obs}, 32'hFFFF_FFFF);
                else
                    chk("phase", {7'd0, obs}, {7'd0, exp_q.pop_front()});
            end
            prev_sig = obs[24:2];
        end
    end

    task automatic advance(input logic nk);
        repeat (2) @(negedge clk);
        tx_done = 1'b1; rx_done = 1'b1; ack_nack = nk; neg = 1'b1;
        @(negedge clk);
        tx_done = 1'b0; rx_done = 1'b0; ack_nack = 1'b0; neg = 1'b0;
    endtask

    task automatic start(input logic [11:0] c, input logic [11:0] d, input logic [2:0] l);
        @(negedge clk);
        ccc_addr = c; data_addr = d; data_len = l; en = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic push_hdr_ok(input logic [11:0] c);
        exp_q.push_back(e_bcast()); exp_q.push_back(e_ack());
        exp_q.push_back(e_ser(c));  exp_q.push_back(e_tbit());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; ccc_addr = '0; data_addr = '0; data_len = '0;
        tx_done = 1'b0; rx_done = 1'b0; ack_nack = 1'b0; neg = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {7'd0, obs}, 32'd0);
        rst_n = 1'b1;

        // T1: len 0, plus done-without-strobe hold check in BCAST
        push_hdr_ok(12'd50); exp_q.push_back(e_done(1'b0));
        start(12'd50, 12'd100, 3'd0);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        chk("hold_tx_mode", o_tx_mode, 3'b001);
        chk("hold_pp_od", o_pp_od, 1'b0);
        repeat (4) advance(1'b0);

        // T2: enable left high through done; new transfer, len 3 from addr 100
        ccc_addr = 12'd60; data_addr = 12'd100; data_len = 3'd3;
        push_hdr_ok(12'd60);
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back(e_ser(12'd100 + 12'(b))); exp_q.push_back(e_tbit());
        end
        exp_q.push_back(e_done(1'b0));
        @(negedge clk);
        ccc_addr = 12'd5; data_addr = 12'd7; data_len = 3'd0;
        repeat (10) advance(1'b0);
        en = 1'b0;
        drain("drain_t2");

        // T3: NACK then ACK
`ifdef BCAST_CCC_RETRY_EN
        exp_q.push_back(e_bcast()); exp_q.push_back(e_ack()); exp_q.push_back(e_rstart());
        push_hdr_ok(12'd50); exp_q.push_back(e_done(1'b0));
        start(12'd50, 12'd100, 3'd0);
        advance(1'b0); advance(1'b1); advance(1'b0);
        repeat (4) advance(1'b0);
`else
        exp_q.push_back(e_bcast()); exp_q.push_back(e_ack()); exp_q.push_back(e_done(1'b1));
        start(12'd50, 12'd100, 3'd0);
        advance(1'b0); advance(1'b1);
`endif
        en = 1'b0;
        drain("drain_t3");

        // T4: NACK on every address phase
`ifdef BCAST_CCC_RETRY_EN
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(e_bcast()); exp_q.push_back(e_ack()); exp_q.push_back(e_rstart());
        end
        exp_q.push_back(e_bcast()); exp_q.push_back(e_ack()); exp_q.push_back(e_done(1'b1));
        start(12'd50, 12'd100, 3'd2);
        for (int r = 0; r < 2; r++) begin
            advance(1'b0); advance(1'b1); advance(1'b0);
        end
        advance(1'b0); advance(1'b1);
`else
        exp_q.push_back(e_bcast()); exp_q.push_back(e_ack()); exp_q.push_back(e_done(1'b1));
        start(12'd50, 12'd100, 3'd2);
        advance(1'b0); advance(1'b1);
`endif
        en = 1'b0;
        drain("drain_t4");

        // T5: enable dropped while serializing data byte 1
        push_hdr_ok(12'd50);
        exp_q.push_back(e_ser(12'd200)); exp_q.push_back(e_tbit()); exp_q.push_back(e_ser(12'd201));
        start(12'd50, 12'd200, 3'd3);
        repeat (6) advance(1'b0);
        en = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {7'd0, obs}, 32'd0);
        repeat (5) @(negedge clk);
        drain("drain_t5");

        // T6: length 7 clamps to 4; data address wraps past 4095
        push_hdr_ok(12'd33);
        exp_q.push_back(e_ser(12'd4094)); exp_q.push_back(e_tbit());
        exp_q.push_back(e_ser(12'd4095)); exp_q.push_back(e_tbit());
        exp_q.push_back(e_ser(12'd0));    exp_q.push_back(e_tbit());
        exp_q.push_back(e_ser(12'd1));    exp_q.push_back(e_tbit());
        exp_q.push_back(e_done(1'b0));
        start(12'd33, 12'd4094, 3'd7);
        repeat (12) advance(1'b0);
        en = 1'b0;
        drain("drain_t6");

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
